// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state encoding and default widths for the PWM generator
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} pwm_state_t;
  localparam int PWM_WIDTH = 16;
  localparam int PWM_PRESCALE_WIDTH = 8;
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk into ticks every pre_sh+1 clocks, held at 0 while clr
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE_WIDTH = PWM_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic [PRESCALE_WIDTH-1:0] pre_sh,
  output logic                      tick
);
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  assign tick = !clr && pre_cnt == pre_sh;
  always_ff @(posedge clk or posedge reset)
    if (reset) pre_cnt <= '0;
    else pre_cnt <= (clr || tick) ? '0 : pre_cnt + 1'b1;
endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: period-aligned PWM with shadowed duty/period/prescale and run/drain FSM
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int PRESCALE_WIDTH = PWM_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          duty,
  input  logic [WIDTH-1:0]          period,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      pwm_out,
  output logic                      period_start,
  output logic                      busy
);
  pwm_state_t state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_nx, duty_sh, period_sh, duty_nx;
  logic [PRESCALE_WIDTH-1:0] pre_sh;
  logic tick, wrap, load, park, pwm_nx;
  pwm_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_pre (
    .clk(clk), .reset(reset), .clr(state == IDLE), .pre_sh(pre_sh), .tick(tick)
  );
  // pwm_out is computed from the cnt/duty_sh that land on the same edge, so it never lags a cycle
  always_comb begin
    wrap = tick && cnt == period_sh;
    load = (state == IDLE && enable) || (state == RUN && wrap);
    park = state == DRAIN && wrap;
    state_nx = state == IDLE ? (enable ? RUN : IDLE) : park ? IDLE : enable ? RUN : DRAIN;
    cnt_nx = (load || park) ? '0 : tick ? cnt + 1'b1 : cnt;
    duty_nx = load ? duty : duty_sh;
    pwm_nx = state_nx != IDLE && cnt_nx < duty_nx;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      pwm_out <= 1'b0;
      period_start <= 1'b0;
      duty_sh <= '0;
      period_sh <= '0;
      pre_sh <= '0;
    end else begin
      cnt <= cnt_nx;
      pwm_out <= pwm_nx;
      period_start <= load;
      if (load) begin
        duty_sh <= duty;
        period_sh <= period;
        pre_sh <= prescale;
      end
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: scoreboard bench; stimulus queues per-period expectations, monitor measures periods
module tb_pwm_generator;
  logic clk = 0, reset = 1, enable = 0;
  logic [15:0] duty = 0, period = 0;
  logic [7:0] prescale = 0;
  logic pwm_out, period_start, busy;
  int nchk = 0, npass = 0;
  typedef struct {int len; int high;} exp_t;
  exp_t q[$];
  pwm_generator dut (
    .clk(clk), .reset(reset), .enable(enable), .duty(duty), .period(period),
    .prescale(prescale), .pwm_out(pwm_out), .period_start(period_start), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int req);
    nchk++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask
  task automatic push(input int len, input int high);
    exp_t e;
    e.len = len;
    e.high = high;
    q.push_back(e);
  endtask
  task automatic next_start();
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = period_start;
    end
    if (!seen) check("period_start_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 500 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) check("busy_fall_timeout", 0, 1);
  endtask
  // monitor: one measured period per expectation; high time must be one contiguous run from the start
  bit inp = 0, fell, runt;
  int len, high;
  always @(negedge clk) begin
    if (reset) inp = 0;
    else begin
      if (inp && (period_start || !busy)) begin
        inp = 0;
        if (q.size() == 0) check("unexpected_period", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("period_len", len, e.len);
          check("period_high", runt ? -1 : high, e.high);
        end
      end
      if (period_start) begin
        inp = 1;
        len = 0;
        high = 0;
        fell = 0;
        runt = 0;
      end
      if (inp) begin
        len++;
        if (pwm_out) begin
          high++;
          if (fell) runt = 1;
        end else fell = 1;
      end
    end
  end
  initial begin
    int lvl, up, bad;
    int steps_exp[7] = '{1, 2, 3, 4, 3, 2, 1};
    repeat (3) @(negedge clk);
    check("reset_pwm_out", pwm_out, 0);
    check("reset_period_start", period_start, 0);
    check("reset_busy", busy, 0);
    reset = 0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    period = 9; prescale = 0; duty = 3;
    push(10, 3);
    enable = 1;
    next_start();
    check("run_busy", busy, 1);
    push(10, 3);
    next_start();
    prescale = 3; period = 4; duty = 2;
    push(20, 8);
    next_start();
    prescale = 0; period = 9; duty = 0;
    push(10, 0);
    next_start();
    duty = 10;
    push(10, 10);
    next_start();
    duty = 16'hFFFF;
    push(10, 10);
    next_start();
    duty = 3;
    push(10, 3);
    next_start();
    repeat (5) @(negedge clk);
    duty = 7;
    push(10, 7);
    next_start();
    duty = 3;
    push(10, 3);
    next_start();
    repeat (2) @(negedge clk);
    enable = 0;
    wait_idle();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || pwm_out) bad++;
    end
    check("idle_hold_cycles_active", bad, 0);
    enable = 1;
    push(10, 3);
    next_start();
    repeat (3) @(negedge clk);
    enable = 0;
    repeat (2) @(negedge clk);
    check("drain_busy", busy, 1);
    enable = 1;
    next_start();
    @(negedge clk);
    check("pwm_high_before_reset", pwm_out, 1);
    #2 reset = 1;
    #1 check("async_reset_pwm_out", pwm_out, 0);
    check("async_reset_busy", busy, 0);
    enable = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    period = 9; prescale = 0;
    lvl = 1; up = 1;
    duty = 16'(lvl);
    push(10, steps_exp[0]);
    enable = 1;
    for (int i = 1; i < 7; i++) begin
      next_start();
      if (up) begin
        if (lvl == 4) begin up = 0; lvl--; end else lvl++;
      end else begin
        if (lvl == 1) begin up = 1; lvl++; end else lvl--;
      end
      duty = 16'(lvl);
      push(10, steps_exp[i]);
    end
    next_start();
    enable = 0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
